toecam_ram_ctrl: RTL and testbench

Controller/arbiter in front of the ToeCam dual-port RAM (one read/write port, one write-only port).
- Clears the whole RAM after reset.
- Serves lookups on the read/write port.
- Arbitrates insert and delete requesters onto the write port.
- Forwards write data when a lookup collides with a same-cycle write, so lookups never return stale data.

---
 rtl/toecam_ram_pkg.sv | 20 ++
 rtl/toecam_rr_arb2.sv | 43 ++++
 rtl/toecam_ram_ctrl.sv | 177 +++++++++++++++++
 tb/tb_toecam_ram_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/toecam_ram_pkg.sv
// ToeCam RAM controller shared definitions.
// Contents: controller FSM state encoding, default RAM geometry, the widths of
// the optional statistics counters (built when TOECAM_RAM_CTRL_STATS_EN is
// defined) and the requester indices used by the write-port arbiter.
package toecam_ram_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,   // clearing the RAM after reset
        ST_RUN  = 1'b1    // serving lookups, inserts and deletes
    } ctrlState_t;

    localparam int A_DEF       = 9;    // RAM address width (depth 2^A)
    localparam int D_DEF       = 64;   // RAM data width
    localparam int STAT_OP_W   = 32;   // lookup/insert/delete counters
    localparam int STAT_COLL_W = 16;   // bypass event counter

    localparam int ARB_INS = 0;        // arbiter request/grant index of inserts
    localparam int ARB_DEL = 1;        // arbiter request/grant index of deletes

endpackage

// File: rtl/toecam_rr_arb2.sv
// Two-requester round-robin arbiter for the RAM write port.
// Ports:
//   Clk, Rst_n : clock, asynchronous active-low reset
//   En         : grants are only issued while high
//   Req[1:0]   : requests, index ARB_INS / ARB_DEL
//   Gnt[1:0]   : one-hot (or zero) grant, combinational from Req and pointer
// The pointer names the side that wins when both request; it comes out of
// reset favouring deletes and hands priority to the other side after a grant.
module toecam_rr_arb2
    import toecam_ram_pkg::*;
(
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       En,
    input  logic [1:0] Req,
    output logic [1:0] Gnt
);

    logic ptrDelQ;

    always_comb begin
        Gnt = 2'b00;
        if (En) begin
            if (Req == 2'b11) begin
                Gnt[ARB_DEL] = ptrDelQ;
                Gnt[ARB_INS] = ~ptrDelQ;
            end else begin
                Gnt = Req;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ptrDelQ <= 1'b1;
        end else if (Gnt[ARB_INS]) begin
            ptrDelQ <= 1'b1;
        end else if (Gnt[ARB_DEL]) begin
            ptrDelQ <= 1'b0;
        end
    end

endmodule

// File: rtl/toecam_ram_ctrl.sv
// ToeCam RAM controller / arbiter.
// After reset it sweeps zeros over every RAM address through the write-only
// port, then serves lookups on the read/write port and arbitrates insert and
// delete requests onto the write port. A lookup that hits the address being
// written in the same cycle returns the newly written value.
// Ports:
//   Clk, Rst_n                     : clock, asynchronous active-low reset
//   InitDone                       : RAM clear complete (RUN state)
//   LkpReq/LkpAddr/LkpGnt          : lookup request handshake
//   LkpVld/LkpData                 : lookup result, one cycle after grant
//   InsReq/InsAddr/InsData/InsGnt  : insert request handshake
//   DelReq/DelAddr/DelGnt          : delete request handshake
//   RamRw*                         : RAM read/write port (used read-only)
//   RamWr*                         : RAM write-only port
// Optional build macro TOECAM_RAM_CTRL_STATS_EN adds the saturating counters
// StatLkp, StatIns, StatDel (granted operations) and StatColl (bypass events),
// counted in RUN only.
module toecam_ram_ctrl
    import toecam_ram_pkg::*;
#(
    parameter int A = A_DEF,
    parameter int D = D_DEF
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    output logic                   InitDone,
`ifdef TOECAM_RAM_CTRL_STATS_EN
    output logic [STAT_OP_W-1:0]   StatLkp,
    output logic [STAT_OP_W-1:0]   StatIns,
    output logic [STAT_OP_W-1:0]   StatDel,
    output logic [STAT_COLL_W-1:0] StatColl,
`endif
    input  logic                   LkpReq,
    input  logic [A-1:0]           LkpAddr,
    output logic                   LkpGnt,
    output logic                   LkpVld,
    output logic [D-1:0]           LkpData,
    input  logic                   InsReq,
    input  logic [A-1:0]           InsAddr,
    input  logic [D-1:0]           InsData,
    output logic                   InsGnt,
    input  logic                   DelReq,
    input  logic [A-1:0]           DelAddr,
    output logic                   DelGnt,
    output logic                   RamRwEnb,
    output logic [A-1:0]           RamRwAddr,
    output logic [D-1:0]           RamRwData,
    input  logic [D-1:0]           RamRwDataOut,
    output logic                   RamWrEnb,
    output logic [A-1:0]           RamWrAddr,
    output logic [D-1:0]           RamWrData
);

    ctrlState_t     stateQ, stateNxt;
    logic [A-1:0]   sweepCntQ;
    logic           run;
    logic [1:0]     wrGnt;
    logic           collision_p0;
    logic           lkpVld_p1;
    logic           collHit_p1;
    logic [D-1:0]   bypData_p1;

    assign run = (stateQ == ST_RUN);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            stateQ <= ST_INIT;
        end else begin
            stateQ <= stateNxt;
        end
    end

    always_comb begin
        stateNxt = stateQ;
        if (stateQ == ST_INIT && sweepCntQ == '1) begin
            stateNxt = ST_RUN;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sweepCntQ <= '0;
        end else if (stateQ == ST_INIT) begin
            sweepCntQ <= sweepCntQ + 1'b1;
        end
    end

    toecam_rr_arb2 uArb (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .En    (run),
        .Req   ({DelReq, InsReq}),
        .Gnt   (wrGnt)
    );

    always_comb begin
        InitDone  = run;
        LkpGnt    = run & LkpReq;
        InsGnt    = wrGnt[ARB_INS];
        DelGnt    = wrGnt[ARB_DEL];
        RamRwEnb  = 1'b0;
        RamRwAddr = LkpAddr;
        RamRwData = '0;
        RamWrEnb  = 1'b0;
        RamWrAddr = '0;
        RamWrData = '0;
        if (stateQ == ST_INIT) begin
            // INIT is also the state held during reset; keep the port quiet then.
            RamWrEnb  = Rst_n;
            RamWrAddr = sweepCntQ;
        end else if (wrGnt[ARB_INS]) begin
            RamWrEnb  = 1'b1;
            RamWrAddr = InsAddr;
            RamWrData = InsData;
        end else if (wrGnt[ARB_DEL]) begin
            RamWrEnb  = 1'b1;
            RamWrAddr = DelAddr;
        end
    end

    // The RAM returns the pre-write contents when read and write hit the same
    // address in one cycle, so the written value is captured for the result.
    assign collision_p0 = LkpGnt & (InsGnt | DelGnt) & (LkpAddr == RamWrAddr);

    // ---- stage p0 -> p1: lookup result cycle ----
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            lkpVld_p1  <= 1'b0;
            collHit_p1 <= 1'b0;
        end else begin
            lkpVld_p1  <= LkpGnt;
            collHit_p1 <= collision_p0;
        end
    end

    always_ff @(posedge Clk) begin
        if (collision_p0) begin
            bypData_p1 <= RamWrData;
        end
    end

    assign LkpVld  = lkpVld_p1;
    assign LkpData = !lkpVld_p1 ? '0 : (collHit_p1 ? bypData_p1 : RamRwDataOut);

`ifdef TOECAM_RAM_CTRL_STATS_EN
    logic [STAT_OP_W-1:0]   statLkpQ, statInsQ, statDelQ;
    logic [STAT_COLL_W-1:0] statCollQ;

    function automatic logic [STAT_OP_W-1:0] satIncOp(input logic [STAT_OP_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [STAT_COLL_W-1:0] satIncColl(input logic [STAT_COLL_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            statLkpQ  <= '0;
            statInsQ  <= '0;
            statDelQ  <= '0;
            statCollQ <= '0;
        end else if (run) begin
            if (LkpGnt)       statLkpQ  <= satIncOp(statLkpQ);
            if (InsGnt)       statInsQ  <= satIncOp(statInsQ);
            if (DelGnt)       statDelQ  <= satIncOp(statDelQ);
            if (collision_p0) statCollQ <= satIncColl(statCollQ);
        end
    end

    assign StatLkp  = statLkpQ;
    assign StatIns  = statInsQ;
    assign StatDel  = statDelQ;
    assign StatColl = statCollQ;
`endif

endmodule

// File: tb/tb_toecam_ram_ctrl.sv
// Bench for toecam_ram_ctrl with A=4, D=64: reset and clear sweep, a
// table of per-cycle vectors in RUN, and the optional statistics counters.
module tb_toecam_ram_ctrl;

    localparam int A = 4;
    localparam int D = 64;

    logic         Clk = 1'b0;
    logic         Rst_n;
    logic         InitDone;
    logic         LkpReq, LkpGnt, LkpVld;
    logic [A-1:0] LkpAddr;
    logic [D-1:0] LkpData;
    logic         InsReq, InsGnt;
    logic [A-1:0] InsAddr;
    logic [D-1:0] InsData;
    logic         DelReq, DelGnt;
    logic [A-1:0] DelAddr;
    logic         RamRwEnb, RamWrEnb;
    logic [A-1:0] RamRwAddr, RamWrAddr;
    logic [D-1:0] RamRwData, RamRwDataOut, RamWrData;
`ifdef TOECAM_RAM_CTRL_STATS_EN
    logic [31:0]  StatLkp, StatIns, StatDel;
    logic [15:0]  StatColl;
`endif

    int nApplied = 0;
    int nMiss    = 0;

    always #5 Clk = ~Clk;

    toecam_ram_ctrl #(.A(A), .D(D)) dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .InitDone     (InitDone),
`ifdef TOECAM_RAM_CTRL_STATS_EN
        .StatLkp      (StatLkp),
        .StatIns      (StatIns),
        .StatDel      (StatDel),
        .StatColl     (StatColl),
`endif
        .LkpReq       (LkpReq),
        .LkpAddr      (LkpAddr),
        .LkpGnt       (LkpGnt),
        .LkpVld       (LkpVld),
        .LkpData      (LkpData),
        .InsReq       (InsReq),
        .InsAddr      (InsAddr),
        .InsData      (InsData),
        .InsGnt       (InsGnt),
        .DelReq       (DelReq),
        .DelAddr      (DelAddr),
        .DelGnt       (DelGnt),
        .RamRwEnb     (RamRwEnb),
        .RamRwAddr    (RamRwAddr),
        .RamRwData    (RamRwData),
        .RamRwDataOut (RamRwDataOut),
        .RamWrEnb     (RamWrEnb),
        .RamWrAddr    (RamWrAddr),
        .RamWrData    (RamWrData)
    );

    // Dual-port RAM with registered read returning pre-write data.
    logic [D-1:0] mem [2**A];
    always @(posedge Clk) begin
        if (RamWrEnb) mem[RamWrAddr] <= RamWrData;
        RamRwDataOut <= mem[RamRwAddr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nApplied++;
        if (act !== exp) begin
            nMiss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic         lkpReq;
        logic [A-1:0] lkpAddr;
        logic         insReq;
        logic [A-1:0] insAddr;
        logic [D-1:0] insData;
        logic         delReq;
        logic [A-1:0] delAddr;
        logic         eLkpGnt;
        logic         eInsGnt;
        logic         eDelGnt;
        logic         eWrEnb;
        logic [A-1:0] eWrAddr;
        logic [D-1:0] eWrData;
        logic         eVld;
        logic [D-1:0] eData;
    } vec_t;

    localparam int NV = 21;
    vec_t tbl [NV];

    task automatic idleInputs();
        LkpReq = 1'b0; LkpAddr = '0;
        InsReq = 1'b0; InsAddr = '0; InsData = '0;
        DelReq = 1'b0; DelAddr = '0;
    endtask

    initial begin
        //           lkp       ins                 del     | gL gI gD wE wA  wD          vld data
        tbl[0]  = '{0, 4'd0, 1, 4'd5, 64'hDEAD, 0, 4'd0,   0, 1, 0, 1, 4'd5, 64'hDEAD, 0, 64'h0};
        tbl[1]  = '{1, 4'd5, 0, 4'd0, 64'h0,    0, 4'd0,   1, 0, 0, 0, 4'd0, 64'h0,    0, 64'h0};
        tbl[2]  = '{0, 4'd0, 0, 4'd0, 64'h0,    0, 4'd0,   0, 0, 0, 0, 4'd0, 64'h0,    1, 64'hDEAD};
        tbl[3]  = '{0, 4'd0, 1, 4'd7, 64'h1,    0, 4'd0,   0, 1, 0, 1, 4'd7, 64'h1,    0, 64'h0};
        tbl[4]  = '{1, 4'd7, 1, 4'd7, 64'h2,    0, 4'd0,   1, 1, 0, 1, 4'd7, 64'h2,    0, 64'h0};
        tbl[5]  = '{1, 4'd7, 0, 4'd0, 64'h0,    1, 4'd7,   1, 0, 1, 1, 4'd7, 64'h0,    1, 64'h2};
        tbl[6]  = '{1, 4'd7, 0, 4'd0, 64'h0,    0, 4'd0,   1, 0, 0, 0, 4'd0, 64'h0,    1, 64'h0};
        tbl[7]  = '{0, 4'd0, 0, 4'd0, 64'h0,    0, 4'd0,   0, 0, 0, 0, 4'd0, 64'h0,    1, 64'h0};
        tbl[8]  = '{0, 4'd0, 1, 4'd3, 64'h33,   1, 4'd4,   0, 1, 0, 1, 4'd3, 64'h33,   0, 64'h0};
        tbl[9]  = '{0, 4'd0, 1, 4'd3, 64'h33,   1, 4'd4,   0, 0, 1, 1, 4'd4, 64'h0,    0, 64'h0};
        tbl[10] = '{0, 4'd0, 1, 4'd3, 64'h33,   1, 4'd4,   0, 1, 0, 1, 4'd3, 64'h33,   0, 64'h0};
        tbl[11] = '{0, 4'd0, 1, 4'd3, 64'h33,   1, 4'd4,   0, 0, 1, 1, 4'd4, 64'h0,    0, 64'h0};
        tbl[12] = '{1, 4'd3, 0, 4'd0, 64'h0,    0, 4'd0,   1, 0, 0, 0, 4'd0, 64'h0,    0, 64'h0};
        tbl[13] = '{1, 4'd5, 0, 4'd0, 64'h0,    0, 4'd0,   1, 0, 0, 0, 4'd0, 64'h0,    1, 64'h33};
        tbl[14] = '{0, 4'd0, 0, 4'd0, 64'h0,    0, 4'd0,   0, 0, 0, 0, 4'd0, 64'h0,    1, 64'hDEAD};
        tbl[15] = '{1, 4'd5, 1, 4'd6, 64'h66,   0, 4'd0,   1, 1, 0, 1, 4'd6, 64'h66,   0, 64'h0};
        tbl[16] = '{1, 4'd6, 0, 4'd0, 64'h0,    0, 4'd0,   1, 0, 0, 0, 4'd0, 64'h0,    1, 64'hDEAD};
        tbl[17] = '{0, 4'd0, 1, 4'd2, 64'h22,   0, 4'd0,   0, 1, 0, 1, 4'd2, 64'h22,   1, 64'h66};
        tbl[18] = '{0, 4'd0, 1, 4'd2, 64'h23,   0, 4'd0,   0, 1, 0, 1, 4'd2, 64'h23,   0, 64'h0};
        tbl[19] = '{0, 4'd0, 1, 4'd8, 64'h88,   1, 4'd9,   0, 0, 1, 1, 4'd9, 64'h0,    0, 64'h0};
        tbl[20] = '{0, 4'd0, 1, 4'd8, 64'h88,   1, 4'd9,   0, 1, 0, 1, 4'd8, 64'h88,   0, 64'h0};

        // Reset state, with a lookup request already pending.
        idleInputs();
        LkpReq = 1'b1;
        Rst_n  = 1'b0;
        repeat (2) @(negedge Clk);
        #1;
        chk("rst.InitDone", InitDone, 0);
        chk("rst.RamWrEnb", RamWrEnb, 0);
        chk("rst.LkpGnt",   LkpGnt,   0);
        chk("rst.LkpVld",   LkpVld,   0);
        chk("rst.LkpData",  LkpData,  0);
        chk("rst.RamRwEnb", RamRwEnb, 0);
        chk("rst.RamRwData", RamRwData, 0);

        // Start a sweep and abort it with reset while the counter is at 9.
        @(negedge Clk);
        Rst_n = 1'b1;
        repeat (9) @(negedge Clk);
        #1;
        chk("mid.RamWrAddr", RamWrAddr, 9);
        chk("mid.RamWrEnb",  RamWrEnb,  1);
        Rst_n = 1'b0;
        #1;
        chk("mid.rst.RamWrEnb", RamWrEnb, 0);
        chk("mid.rst.InitDone", InitDone, 0);
        @(negedge Clk);
        Rst_n = 1'b1;

        // Full sweep from address 0; the held lookup must not be granted.
        for (int i = 0; i < 2**A; i++) begin
            #1;
            chk($sformatf("sweep%0d.RamWrEnb", i),  RamWrEnb,  1);
            chk($sformatf("sweep%0d.RamWrAddr", i), RamWrAddr, i);
            chk($sformatf("sweep%0d.RamWrData", i), RamWrData, 0);
            chk($sformatf("sweep%0d.LkpGnt", i),    LkpGnt,    0);
            chk($sformatf("sweep%0d.InitDone", i),  InitDone,  0);
            @(negedge Clk);
        end
        #1;
        chk("run.InitDone", InitDone, 1);
        chk("run.LkpGnt",   LkpGnt,   1);
        chk("run.RamWrEnb", RamWrEnb, 0);
        LkpReq = 1'b0;
        @(negedge Clk);

        // Per-cycle vectors in RUN.
        for (int i = 0; i < NV; i++) begin
            LkpReq  = tbl[i].lkpReq;  LkpAddr = tbl[i].lkpAddr;
            InsReq  = tbl[i].insReq;  InsAddr = tbl[i].insAddr; InsData = tbl[i].insData;
            DelReq  = tbl[i].delReq;  DelAddr = tbl[i].delAddr;
            #2;
            chk($sformatf("v%0d.LkpGnt", i),    LkpGnt,    tbl[i].eLkpGnt);
            chk($sformatf("v%0d.InsGnt", i),    InsGnt,    tbl[i].eInsGnt);
            chk($sformatf("v%0d.DelGnt", i),    DelGnt,    tbl[i].eDelGnt);
            chk($sformatf("v%0d.RamWrEnb", i),  RamWrEnb,  tbl[i].eWrEnb);
            chk($sformatf("v%0d.RamWrAddr", i), RamWrAddr, tbl[i].eWrAddr);
            chk($sformatf("v%0d.RamWrData", i), RamWrData, tbl[i].eWrData);
            chk($sformatf("v%0d.LkpVld", i),    LkpVld,    tbl[i].eVld);
            chk($sformatf("v%0d.LkpData", i),   LkpData,   tbl[i].eData);
            chk($sformatf("v%0d.RamRwAddr", i), RamRwAddr, tbl[i].lkpAddr);
            @(negedge Clk);
        end
        idleInputs();

`ifdef TOECAM_RAM_CTRL_STATS_EN
        Rst_n = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b1;
        repeat (2**A) @(negedge Clk);
        #1;
        chk("stat.InitDone", InitDone, 1);
        chk("stat.init.StatIns", StatIns, 0);
        LkpReq = 1'b1; LkpAddr = 4'd0;
        @(negedge Clk);
        LkpReq = 1'b0; InsReq = 1'b1; InsAddr = 4'd1; InsData = 64'h5;
        @(negedge Clk);
        LkpReq = 1'b1; LkpAddr = 4'd2; InsAddr = 4'd2; InsData = 64'h6;
        @(negedge Clk);
        InsReq = 1'b0; DelReq = 1'b1; DelAddr = 4'd3; LkpAddr = 4'd4;
        @(negedge Clk);
        idleInputs();
        #1;
        chk("stat.StatLkp",  StatLkp,  3);
        chk("stat.StatIns",  StatIns,  2);
        chk("stat.StatDel",  StatDel,  1);
        chk("stat.StatColl", StatColl, 1);
        force dut.statLkpQ = '1;
        @(negedge Clk);
        release dut.statLkpQ;
        LkpReq = 1'b1; LkpAddr = 4'd0;
        @(negedge Clk);
        LkpReq = 1'b0;
        #1;
        chk("stat.sat.StatLkp", StatLkp, 32'hFFFF_FFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiss);
        $finish;
    end

endmodule
